// File: rtl/diff_commit_queue.sv
// diff_commit_queue: in-order commit/exception/store record buffer feeding the
// difftest bridge. Accepts up to IN_W records per cycle into a DEPTH-entry FIFO
// and drains each cycle a legal event group: up to 4 commit slots, at most one
// exception event and at most one store event, all registered.
// Optional feature macro: DIFF_COMMIT_WDOG_EN (builds the output-idle watchdog;
// without it wdog_timeout is tied low).
module diff_commit_queue #(
    parameter int unsigned IN_W        = 2,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WDOG_CYCLES = 100000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [IN_W-1:0]         in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_kind,
    input  logic [IN_W*274-1:0]     in_rec,
    input  logic [IN_W*18-1:0]      in_excp,
    input  logic [IN_W*200-1:0]     in_store,
    output logic [3:0]              out_valid,
    output logic [4*274-1:0]        out_rec,
    output logic                    out_excp_valid,
    output logic [17:0]             out_excp,
    output logic [31:0]             out_excp_pc,
    output logic [31:0]             out_excp_inst,
    output logic [199:0]            out_store,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_noncontig,
    output logic                    wdog_timeout
);

    localparam int unsigned REC_W     = 274;
    localparam int unsigned EXC_W     = 18;
    localparam int unsigned ST_W      = 200;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned PC_LSB    = 128;
    localparam int unsigned INSTR_LSB = 192;

    // FIFO storage (no reset needed: validity is tracked by pointers/occupancy)
    logic             kind_q  [DEPTH];
    logic [REC_W-1:0] rec_q   [DEPTH];
    logic [EXC_W-1:0] excp_q  [DEPTH];
    logic [ST_W-1:0]  store_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          err_q, err_d;

    // enqueue side
    logic            pfx_run;
    logic [IN_W-1:0] lane_pfx;
    logic [IN_W-1:0] lane_wr;
    logic [CW-1:0]   n_enq;
    logic [CW-1:0]   free_slots;

    // drain side
    logic [CW-1:0]    n_deq;
    logic             drain_done;
    logic [1:0]       slot_n;
    logic [AW-1:0]    scan_idx;
    logic [REC_W-1:0] slot_rec_d [4];

    logic [3:0]         out_valid_q, out_valid_d;
    logic [4*REC_W-1:0] out_rec_q, out_rec_d;
    logic               out_excp_valid_q, out_excp_valid_d;
    logic [EXC_W-1:0]   out_excp_q, out_excp_d;
    logic [31:0]        out_excp_pc_q, out_excp_pc_d;
    logic [31:0]        out_excp_inst_q, out_excp_inst_d;
    logic [ST_W-1:0]    out_store_q, out_store_d;

    assign free_slots = CW'(DEPTH) - occ_q;
    assign in_ready   = (free_slots >= CW'(IN_W));

    // Keep only the contiguous valid prefix from lane 0 and count the lanes written
    always_comb begin
        pfx_run  = 1'b1;
        lane_pfx = '0;
        lane_wr  = '0;
        n_enq    = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            pfx_run     = pfx_run & in_valid[i];
            lane_pfx[i] = pfx_run;
            lane_wr[i]  = pfx_run & in_ready;
            if (pfx_run && in_ready) begin
                n_enq = n_enq + CW'(1);
            end
        end
    end

    // Write accepted lanes into consecutive FIFO entries in lane order
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (lane_wr[i]) begin
                kind_q[wr_ptr_q + AW'(i)]  <= in_kind[i];
                rec_q[wr_ptr_q + AW'(i)]   <= in_rec[i*REC_W +: REC_W];
                excp_q[wr_ptr_q + AW'(i)]  <= in_excp[i*EXC_W +: EXC_W];
                store_q[wr_ptr_q + AW'(i)] <= in_store[i*ST_W +: ST_W];
            end
        end
    end

    // Scan up to 4 head entries; a store commit or an exception closes the group
    always_comb begin
        out_valid_d      = '0;
        out_excp_valid_d = 1'b0;
        out_excp_d       = '0;
        out_excp_pc_d    = '0;
        out_excp_inst_d  = '0;
        out_store_d      = '0;
        n_deq            = '0;
        drain_done       = 1'b0;
        slot_n           = '0;
        scan_idx         = '0;
        for (int unsigned s = 0; s < 4; s++) begin
            slot_rec_d[s] = '0;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            scan_idx = rd_ptr_q + AW'(k);
            if (!drain_done && (CW'(k) < occ_q)) begin
                n_deq = n_deq + CW'(1);
                if (kind_q[scan_idx]) begin
                    out_excp_valid_d = 1'b1;
                    out_excp_d       = excp_q[scan_idx];
                    out_excp_pc_d    = rec_q[scan_idx][PC_LSB +: 32];
                    out_excp_inst_d  = rec_q[scan_idx][INSTR_LSB +: 32];
                    drain_done       = 1'b1;
                end else begin
                    out_valid_d[slot_n] = 1'b1;
                    slot_rec_d[slot_n]  = rec_q[scan_idx];
                    slot_n              = slot_n + 2'd1;
                    if (store_q[scan_idx][ST_W-1 -: 8] != '0) begin
                        out_store_d = store_q[scan_idx];
                        drain_done  = 1'b1;
                    end
                end
            end
        end
        out_rec_d = '0;
        for (int unsigned s = 0; s < 4; s++) begin
            out_rec_d[s*REC_W +: REC_W] = slot_rec_d[s];
        end
    end

    // Pointer, occupancy and sticky-error next state
    always_comb begin
        wr_ptr_d = wr_ptr_q + n_enq[AW-1:0];
        rd_ptr_d = rd_ptr_q + n_deq[AW-1:0];
        occ_d    = occ_q + n_enq - n_deq;
        err_d    = err_q | (in_valid != lane_pfx);
    end

    // FIFO bookkeeping and registered bridge outputs, rewritten every cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            err_q            <= 1'b0;
            out_valid_q      <= '0;
            out_rec_q        <= '0;
            out_excp_valid_q <= 1'b0;
            out_excp_q       <= '0;
            out_excp_pc_q    <= '0;
            out_excp_inst_q  <= '0;
            out_store_q      <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            err_q            <= err_d;
            out_valid_q      <= out_valid_d;
            out_rec_q        <= out_rec_d;
            out_excp_valid_q <= out_excp_valid_d;
            out_excp_q       <= out_excp_d;
            out_excp_pc_q    <= out_excp_pc_d;
            out_excp_inst_q  <= out_excp_inst_d;
            out_store_q      <= out_store_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_rec        = out_rec_q;
    assign out_excp_valid = out_excp_valid_q;
    assign out_excp       = out_excp_q;
    assign out_excp_pc    = out_excp_pc_q;
    assign out_excp_inst  = out_excp_inst_q;
    assign out_store      = out_store_q;
    assign occupancy      = occ_q;
    assign err_noncontig  = err_q;

`ifdef DIFF_COMMIT_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_q, wdog_d;

    // Count cycles with no slot or exception output; saturate at the limit
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if ((out_valid_q != '0) || out_excp_valid_q) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WW'(WDOG_CYCLES)) begin
            wdog_cnt_d = wdog_cnt_q + WW'(1);
        end
        wdog_d = wdog_q | (wdog_cnt_d == WW'(WDOG_CYCLES));
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign wdog_timeout = wdog_q;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = |WDOG_CYCLES;
    assign wdog_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_diff_commit_queue.sv
// Scoreboard bench for diff_commit_queue: directed stimulus pushes hand-derived
// expected event groups; a negedge monitor pops and compares each output group.
module tb_diff_commit_queue;

    localparam int IN_W  = 2;
    localparam int DEPTH = 16;
`ifdef DIFF_COMMIT_WDOG_EN
    localparam int WDOG = 50;
`else
    localparam int WDOG = 100000;
`endif

    logic                   clock;
    logic                   resetn;
    logic [IN_W-1:0]        in_valid;
    logic                   in_ready;
    logic [IN_W-1:0]        in_kind;
    logic [IN_W*274-1:0]    in_rec;
    logic [IN_W*18-1:0]     in_excp;
    logic [IN_W*200-1:0]    in_store;
    logic [3:0]             out_valid;
    logic [4*274-1:0]       out_rec;
    logic                   out_excp_valid;
    logic [17:0]            out_excp;
    logic [31:0]            out_excp_pc;
    logic [31:0]            out_excp_inst;
    logic [199:0]           out_store;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   err_noncontig;
    logic                   wdog_timeout;

    diff_commit_queue #(
        .IN_W        (IN_W),
        .DEPTH       (DEPTH),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_rec         (in_rec),
        .in_excp        (in_excp),
        .in_store       (in_store),
        .out_valid      (out_valid),
        .out_rec        (out_rec),
        .out_excp_valid (out_excp_valid),
        .out_excp       (out_excp),
        .out_excp_pc    (out_excp_pc),
        .out_excp_inst  (out_excp_inst),
        .out_store      (out_store),
        .occupancy      (occupancy),
        .err_noncontig  (err_noncontig),
        .wdog_timeout   (wdog_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][63:0] pc;
        logic             ev;
        logic [17:0]      excp;
        logic [63:0]      epc;
        logic [7:0]       sv;
        logic [63:0]      spc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t e;
    int   n_chk;
    int   n_pass;

    function automatic logic [273:0] mkrec(input logic [63:0] pc);
        logic [31:0] ins;
        ins = pc[31:0] ^ 32'h00ff_00ff;
        return {1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, pc[9:2], 32'h0, ins, pc, ~pc, 64'h0};
    endfunction

    function automatic logic [199:0] mkst(input logic [7:0] sv, input logic [63:0] pc);
        return {sv, pc ^ 64'h8000_0000_0000_0000, pc, ~pc};
    endfunction

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_lane(input int l, input logic v, input logic kind, input logic [63:0] pc,
                            input logic [7:0] sv, input logic [5:0] cause);
        in_valid[l]            = v;
        in_kind[l]             = kind;
        in_rec[l*274 +: 274]   = mkrec(pc);
        in_excp[l*18 +: 18]    = {1'b0, 11'd0, cause};
        in_store[l*200 +: 200] = mkst(sv, pc);
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_kind  = '0;
    endtask

    task automatic drain_wait();
        int cyc;
        cyc = 0;
        while ((occupancy != 0 || q.size() != 0) && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("drain_complete", (q.size() == 0) && (occupancy == 0), 64'(q.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    // Monitor: every output group must match the head of the expected queue
    always @(negedge clock) begin
        if (resetn && (out_valid != 4'b0 || out_excp_valid)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1'b0, 64'(out_valid), 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("slot_valid", out_valid == mon_e.v, 64'(out_valid), 64'(mon_e.v));
                for (int i = 0; i < 4; i++) begin
                    if (mon_e.v[i])
                        chk("slot_rec_pc", out_rec[i*274 +: 274] == mkrec(mon_e.pc[i]),
                            out_rec[i*274+128 +: 64], mon_e.pc[i]);
                end
                chk("excp_valid", out_excp_valid == mon_e.ev, 64'(out_excp_valid), 64'(mon_e.ev));
                if (mon_e.ev) begin
                    chk("excp_field", out_excp == mon_e.excp, 64'(out_excp), 64'(mon_e.excp));
                    chk("excp_pc", out_excp_pc == mon_e.epc[31:0], 64'(out_excp_pc), 64'(mon_e.epc[31:0]));
                    chk("excp_inst", out_excp_inst == (mon_e.epc[31:0] ^ 32'h00ff_00ff),
                        64'(out_excp_inst), 64'(mon_e.epc[31:0] ^ 32'h00ff_00ff));
                end
                chk("store_valid", out_store[199:192] == mon_e.sv, 64'(out_store[199:192]), 64'(mon_e.sv));
                if (mon_e.sv != 8'h0)
                    chk("store_data", out_store == mkst(mon_e.sv, mon_e.spc), out_store[127:64], mon_e.spc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] base;
        int          max_occ;
        int          cyc;
        logic        accepted;

        n_chk = 0;
        n_pass = 0;
        resetn = 1'b0;
        in_valid = '0;
        in_kind = '0;
        in_rec = '0;
        in_excp = '0;
        in_store = '0;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid == 4'b0, 64'(out_valid), 64'd0);
        chk("rst_out_rec", out_rec == '0, out_rec[63:0], 64'd0);
        chk("rst_excp_valid", out_excp_valid == 1'b0, 64'(out_excp_valid), 64'd0);
        chk("rst_excp_fields", {out_excp, out_excp_pc, out_excp_inst} == '0, 64'(out_excp_pc), 64'd0);
        chk("rst_store", out_store == '0, out_store[63:0], 64'd0);
        chk("rst_occupancy", occupancy == 0, 64'(occupancy), 64'd0);
        chk("rst_err", err_noncontig == 1'b0, 64'(err_noncontig), 64'd0);
        chk("rst_wdog", wdog_timeout == 1'b0, 64'(wdog_timeout), 64'd0);
        chk("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        chk("idle_occupancy", occupancy == 0, 64'(occupancy), 64'd0);
        chk("idle_out_valid", out_valid == 4'b0, 64'(out_valid), 64'd0);

        // ---- two leading store commits hold back the 6 plain commits: 4 then 2 ----
        e = '0; e.v = 4'b0001; e.pc[0] = 64'h1c00_0100; e.sv = 8'h01; e.spc = 64'h1c00_0100; q.push_back(e);
        e = '0; e.v = 4'b0001; e.pc[0] = 64'h1c00_0104; e.sv = 8'h01; e.spc = 64'h1c00_0104; q.push_back(e);
        e = '0; e.v = 4'b1111;
        e.pc[0] = 64'h1c00_0000; e.pc[1] = 64'h1c00_0004; e.pc[2] = 64'h1c00_0008; e.pc[3] = 64'h1c00_000c;
        q.push_back(e);
        e = '0; e.v = 4'b0011; e.pc[0] = 64'h1c00_0010; e.pc[1] = 64'h1c00_0014; q.push_back(e);
        @(negedge clock);
        set_lane(0, 1'b1, 1'b0, 64'h1c00_0100, 8'h01, 6'h0);
        set_lane(1, 1'b1, 1'b0, 64'h1c00_0104, 8'h01, 6'h0);
        for (int n = 0; n < 6; n += 2) begin
            @(negedge clock);
            chk("burst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
            set_lane(0, 1'b1, 1'b0, 64'h1c00_0000 + 64'(4*n), 8'h0, 6'h0);
            set_lane(1, 1'b1, 1'b0, 64'h1c00_0000 + 64'(4*(n+1)), 8'h0, 6'h0);
        end
        @(negedge clock);
        idle_inputs();
        drain_wait();

        // ---- commit followed by exception in one cycle ----
        e = '0; e.v = 4'b0001; e.pc[0] = 64'h1c00_000c; e.ev = 1'b1;
        e.excp = {1'b0, 11'd0, 6'h0b}; e.epc = 64'h1c00_0010; q.push_back(e);
        @(negedge clock);
        set_lane(0, 1'b1, 1'b0, 64'h1c00_000c, 8'h0, 6'h0);
        set_lane(1, 1'b1, 1'b1, 64'h1c00_0010, 8'h0, 6'h0b);
        @(negedge clock);
        idle_inputs();
        drain_wait();

        // ---- A, B(store 0x0f), C ----
        e = '0; e.v = 4'b0011; e.pc[0] = 64'h1c00_0200; e.pc[1] = 64'h1c00_0204;
        e.sv = 8'h0f; e.spc = 64'h1c00_0204; q.push_back(e);
        e = '0; e.v = 4'b0001; e.pc[0] = 64'h1c00_0208; q.push_back(e);
        @(negedge clock);
        set_lane(0, 1'b1, 1'b0, 64'h1c00_0200, 8'h00, 6'h0);
        set_lane(1, 1'b1, 1'b0, 64'h1c00_0204, 8'h0f, 6'h0);
        @(negedge clock);
        set_lane(0, 1'b1, 1'b0, 64'h1c00_0208, 8'h00, 6'h0);
        set_lane(1, 1'b0, 1'b0, 64'h0, 8'h00, 6'h0);
        @(negedge clock);
        idle_inputs();
        drain_wait();

        // ---- store-commit stall: drain 1/cycle while feeding 2/cycle ----
        base = 64'h1c00_1000;
        max_occ = 0;
        for (int n = 0; n < 40; n += 2) begin
            @(negedge clock);
            set_lane(0, 1'b1, 1'b0, base + 64'(4*n), 8'hff, 6'h0);
            set_lane(1, 1'b1, 1'b0, base + 64'(4*(n+1)), 8'hff, 6'h0);
            accepted = 1'b0;
            cyc = 0;
            while (!accepted && cyc < 50) begin
                if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
                if (occupancy == DEPTH-1)
                    chk("ready_low_at_15", in_ready == 1'b0, 64'(in_ready), 64'd0);
                if (in_ready) begin
                    accepted = 1'b1;
                end else begin
                    @(negedge clock);
                    cyc++;
                end
            end
            if (!accepted) chk("enqueue_accept", 1'b0, 64'(occupancy), 64'(DEPTH-IN_W));
            for (int l = 0; l < 2; l++) begin
                e = '0; e.v = 4'b0001; e.pc[0] = base + 64'(4*(n+l));
                e.sv = 8'hff; e.spc = base + 64'(4*(n+l)); q.push_back(e);
            end
        end
        @(negedge clock);
        idle_inputs();
        drain_wait();
        chk("max_occupancy", max_occ == DEPTH-1, 64'(max_occ), 64'(DEPTH-1));

        // ---- non-contiguous lanes: flag set, nothing enqueued ----
        chk("err_before", err_noncontig == 1'b0, 64'(err_noncontig), 64'd0);
        @(negedge clock);
        set_lane(0, 1'b0, 1'b0, 64'h1c00_0300, 8'h0, 6'h0);
        set_lane(1, 1'b1, 1'b0, 64'h1c00_0304, 8'h0, 6'h0);
        @(negedge clock);
        idle_inputs();
        chk("noncontig_occupancy", occupancy == 0, 64'(occupancy), 64'd0);
        chk("noncontig_err", err_noncontig == 1'b1, 64'(err_noncontig), 64'd1);
        repeat (3) @(negedge clock);
        chk("noncontig_sticky", err_noncontig == 1'b1, 64'(err_noncontig), 64'd1);

        // ---- reset mid-operation discards buffered records ----
        set_lane(0, 1'b1, 1'b0, 64'h1c00_0400, 8'h0, 6'h0);
        set_lane(1, 1'b1, 1'b0, 64'h1c00_0404, 8'h0, 6'h0);
        @(negedge clock);
        idle_inputs();
        chk("pre_reset_occupancy", occupancy == 2, 64'(occupancy), 64'd2);
        resetn = 1'b0;
        #1;
        chk("mid_reset_occupancy", occupancy == 0, 64'(occupancy), 64'd0);
        chk("mid_reset_err", err_noncontig == 1'b0, 64'(err_noncontig), 64'd0);
        chk("mid_reset_out_valid", out_valid == 4'b0, 64'(out_valid), 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        // ---- watchdog ----
`ifdef DIFF_COMMIT_WDOG_EN
        repeat (49) @(negedge clock);
        chk("wdog_before_limit", wdog_timeout == 1'b0, 64'(wdog_timeout), 64'd0);
        @(negedge clock);
        chk("wdog_at_limit", wdog_timeout == 1'b1, 64'(wdog_timeout), 64'd1);
        repeat (20) @(negedge clock);
        chk("wdog_held", wdog_timeout == 1'b1, 64'(wdog_timeout), 64'd1);
        resetn = 1'b0;
        #1;
        chk("wdog_reset", wdog_timeout == 1'b0, 64'(wdog_timeout), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
`else
        repeat (60) @(negedge clock);
        chk("wdog_tied_low", wdog_timeout == 1'b0, 64'(wdog_timeout), 64'd0);
`endif
        repeat (3) @(negedge clock);
        chk("scoreboard_empty", q.size() == 0, 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
